// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding, default operand width and the overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand / result width in bits
    localparam int c_DEFAULT_WIDTH = 8;

    // FSM state encoding (2 bits)
    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    // Two's-complement overflow: carry into the MSB differs from carry out
    function automatic logic calc_ovf(input logic carry_into_msb, input logic carry_out);
        return carry_into_msb ^ carry_out;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full-adder slice used as the arithmetic core of
//               the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial two's-complement adder. Operands are accepted in
//               IDLE, processed LSB first through one full-adder slice (one
//               bit per RUN cycle) and the result is offered in DONE with a
//               valid/ready handshake. The result registers keep the last
//               result until the next operation completes.
//               Optional macro SERIAL_ADDER_SUB_EN: when defined, sub=1 at
//               acceptance performs a-b (b inverted, carry-in forced to 1).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter wide enough to hold 0..WIDTH
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_fa_s;
    logic               w_fa_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c0;

    // The slice on the last RUN cycle works on the MSB
    assign w_last = (r_cnt == c_CNT_LAST);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; the caller's carry-in is not used for a-b
    assign w_b_load = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;
`else
    // Addition only; sub is folded in with a zero mask so the port stays
    // referenced without affecting the result
    assign w_b_load = b;
    assign w_c0     = cin | (sub & 1'b0);
`endif

    // Per-bit arithmetic slice: current LSBs plus the carry flop
    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_s),
        .cout (w_fa_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH bit cycles, wait for consumer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)  w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last)    w_next_state = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_next_state = c_ST_IDLE;
            default:                  w_next_state = c_ST_IDLE;
        endcase
    end

    // Output decode: handshake flags follow the state directly
    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
    end

    // Datapath: operand shift registers, carry flop, counter and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c0;
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_c;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    // On the MSB cycle r_carry is the carry into the MSB;
                    // publish the completed result in one step
                    if (w_last) begin
                        r_sum  <= {w_fa_s, r_res[WIDTH-1:1]};
                        r_cout <= w_fa_c;
                        r_ovf  <= calc_ovf(r_carry, w_fa_c);
                    end
                end
                default: begin
                    // DONE (and unused codes): hold everything
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
//               Sub tests follow SERIAL_ADDER_SUB_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation and wait for out_valid. edges counts clock
    // edges with the accepting edge as edge 1; 40 means the wait expired.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tcin, input logic tsub, output int edges);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Accept the pending result with a one-cycle out_ready pulse
    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 8'h00)      begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf got=%b want=00", {cout, ovf}); end
    endtask

    task automatic test_add();
        logic [7:0] va   [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] vb   [5] = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h00};
        logic       vc   [5] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        logic [7:0] esum [5] = '{8'h10, 8'h00, 8'h80, 8'h00, 8'h00};
        logic       ecout[5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        logic       eovf [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, lat);
            total++; if (lat !== 9) begin bad++; $display("FAIL add%0d_latency got=%0d want=9", i, lat); end
            total++; if (sum !== esum[i]) begin bad++; $display("FAIL add%0d_sum got=%h want=%h", i, sum, esum[i]); end
            total++; if (cout !== ecout[i]) begin bad++; $display("FAIL add%0d_cout got=%b want=%b", i, cout, ecout[i]); end
            total++; if (ovf !== eovf[i]) begin bad++; $display("FAIL add%0d_ovf got=%b want=%b", i, ovf, eovf[i]); end
            consume();
            total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL add%0d_release got=%b want=10", i, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_sub();
        int lat;
`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
        total++; if ({sum, cout, ovf} !== {8'hFE, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_5m7 got=%h/%b/%b want=fe/0/0", sum, cout, ovf); end
        consume();
        do_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
        total++; if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_80m1 got=%h/%b/%b want=7f/1/1", sum, cout, ovf); end
        consume();
`else
        // sub must be ignored: plain a+b+cin
        do_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
        total++; if ({sum, cout, ovf} !== {8'h0C, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_ignored got=%h/%b/%b want=0c/0/0", sum, cout, ovf); end
        consume();
`endif
        total++; if (lat !== 9) begin bad++; $display("FAIL sub_latency got=%0d want=9", lat); end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d want=9", lat); end
        // A new request while DONE must be ignored
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({sum, cout, ovf, in_ready, out_valid} !== {8'h46, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%h/%b/%b rdy=%b vld=%b want=46/0/0 rdy=0 vld=1", i, sum, cout, ovf, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        consume();
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b want=10", {in_ready, out_valid}); end
        @(posedge clk); #1;
        total++; if (sum !== 8'h46) begin bad++; $display("FAIL bp_retain got=%h want=46", sum); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_run got rdy=%b vld=%b %h/%b/%b want rdy=1 vld=0 00/0/0", in_ready, out_valid, sum, cout, ovf);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_valid got=%0d want=0", seen); end
        do_op(8'h03, 8'h04, 1'b0, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {8'h07, 1'b0, 1'b0}) begin bad++; $display("FAIL rst_after_op got=%h/%b/%b want=07/0/0", sum, cout, ovf); end
        consume();
    endtask

    task automatic test_back_to_back();
        int t [3] = '{0, 0, 0};
        int nres;
        int extra;
        nres = 0;
        a = 8'h21; b = 8'h10; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 1; c <= 60 && nres < 3; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                t[nres] = c;
                nres++;
                total++; if (sum !== 8'h31) begin bad++; $display("FAIL b2b_sum%0d got=%h want=31", nres, sum); end
                if (nres == 3) in_valid = 1'b0;
            end
        end
        extra = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        out_ready = 1'b0;
        total++; if (nres !== 3)  begin bad++; $display("FAIL b2b_count got=%0d want=3", nres); end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_extra got=%0d want=0", extra); end
        total++; if (t[1] - t[0] !== 10) begin bad++; $display("FAIL b2b_gap1 got=%0d want=10", t[1] - t[0]); end
        total++; if (t[2] - t[1] !== 10) begin bad++; $display("FAIL b2b_gap2 got=%0d want=10", t[2] - t[1]); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid input 1: operands present.
REQ-004 SHALL have port in_ready output 1: block can accept operands.
REQ-005 SHALL have port a input WIDTH: operand A.
REQ-006 SHALL have port b input WIDTH: operand B.
REQ-007 SHALL have port cin input 1: carry-in.
REQ-008 SHALL have port sub input 1: subtract request (see Configuration).
REQ-009 SHALL have port out_valid output 1: result present.
REQ-010 SHALL have port out_ready input 1: consumer accepts the result.
REQ-011 SHALL have port sum output WIDTH: result.
REQ-012 SHALL have port cout output 1: carry-out of the MSB.
REQ-013 SHALL have port ovf output 1: two's-complement overflow (carry into MSB XOR cout).

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE, in_valid=1: at that edge the block SHALL latch a, b and the initial carry into shift registers, clear the bit counter, and go to RUN. It SHALL ignore in_valid in RUN and DONE.
REQ-017 RUN: each cycle SHALL present the current LSBs of A and B plus the carry flop to one full-adder slice, shift the sum bit into the result register from the MSB side, register the slice carry, and increment the counter.
REQ-018 The MSB bit SHALL be processed on the WIDTH-th RUN cycle. On that cycle the block SHALL capture the carry into the MSB, then enter DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 clock edges after the accepting edge.
REQ-020 DONE: sum, cout and ovf SHALL be held stable while out_ready=0. With out_ready=1, the block SHALL return to IDLE on that edge.
REQ-021 There is no overlap, so throughput is one operation per WIDTH+2 cycles minimum. in_ready SHALL rise on the edge the result is consumed.
REQ-022 Outputs SHALL retain the last result in IDLE until the next operation's DONE.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with cout equal to bit WIDTH of a+b+cin.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and set sum=0, cout=0, ovf=0, out_valid=0, counter=0 and carry flop=0; in_ready SHALL be 1 after reset.
REQ-025 Reset during RUN or DONE SHALL abandon the operation and produce no out_valid pulse for it.
REQ-026 Reset SHALL take priority over an in_valid/out_ready handshake on the same edge.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN defined: when sub=1 at acceptance, the block SHALL latch ~b and force the initial carry to 1 (cin ignored), giving a-b; cout=1 means no borrow.
REQ-028 Macro SERIAL_ADDER_SUB_EN undefined: the sub port SHALL exist but be ignored; the block SHALL always add with cin.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE/RUN/DONE, 2 bits) and the default width constant (8).
REQ-030 The block SHALL instantiate exactly one existing full_adder as its per-bit slice. The sequencing, shift registers and carry flop SHALL be in serial_adder.

Verification
REQ-031 a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0, ovf=0; out_valid rises 9 edges after acceptance.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Also a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-033 With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0. a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next edge.
REQ-035 rst=1 on the 4th RUN cycle -> IDLE next edge, all outputs 0, no out_valid. A following operation a=8'h03, b=8'h04 -> sum=8'h07.
REQ-036 Back-to-back: in_valid held high with out_ready=1 over 3 operations -> exactly 3 results at a spacing of WIDTH+2 cycles.
